// File: rtl/bit_serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder: FSM state encoding
// and the default operand width.
package bit_serial_adder_pkg;

  localparam int ST_W          = 2;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Last value the bit counter reaches before the result is complete.
  function automatic int last_bit_index(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/bit_serial_adder_fa.sv
// One-bit full-adder cell used as the single arithmetic slice of the
// bit-serial adder.
module bit_serial_adder_fa
  import bit_serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_half_sum;

  // Sum and carry of one bit position.
  always_comb begin
    w_half_sum = a ^ b;
    sum        = w_half_sum ^ cin;
    cout       = (a & b) | (cin & w_half_sum);
  end

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit per clock, LSB first, with a
// valid/ready handshake on the operand side and on the result side.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(last_bit_index(WIDTH));

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic w_fa_sum;
  logic w_fa_cout;

  bit_serial_adder_fa u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  // Handshake flags are registered next to the state so every output comes
  // straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_a_sh      <= {WIDTH{1'b0}};
      r_b_sh      <= {WIDTH{1'b0}};
      r_sum_sh    <= {WIDTH{1'b0}};
      r_carry     <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a_sh      <= a;
            r_b_sh      <= b;
            r_carry     <= cin;
            r_cnt       <= {CNT_W{1'b0}};
            r_state     <= ST_RUN;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b1;
          end else begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end

        ST_RUN: begin
          r_sum_sh <= {w_fa_sum, r_sum_sh[WIDTH-1:1]};
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_carry  <= w_fa_cout;
          // Counter parks on the last index instead of wrapping.
          if (r_cnt == CNT_LAST) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt       <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            r_state     <= ST_RUN;
            r_out_valid <= 1'b0;
          end
          r_in_ready <= 1'b0;
          r_busy     <= 1'b1;
        end

        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end else begin
            r_state     <= ST_DONE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum_sh;
  assign cout      = r_carry;

endmodule
